// File: rtl/neuron_mac_pkg.sv
// Fixed-point types, limits and shared arithmetic helpers for the neuron MAC.
package neuron_mac_pkg;

    // frac_t: signed Q3.12; unit_t: unsigned Q0.8 in [0, 1)
    localparam int unsigned FRAC_W  = 16;
    localparam int unsigned FRAC_FB = 12;
    localparam int unsigned UNIT_W  = 8;
    localparam int unsigned PROD_W  = 2 * FRAC_W;

    typedef logic signed [FRAC_W-1:0] frac_t;
    typedef logic        [UNIT_W-1:0] unit_t;

    // Sum plus overflow indication from the saturating adder
    typedef struct packed {
        frac_t sum;
        logic  ovf;
    } frac_sum_t;

    typedef enum logic [1:0] {
        ACT_IDENT = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_CLAMP = 2'd2
    } act_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_ACTV  = 3'd3,
        ST_OUT   = 3'd4
    } state_e;

    localparam frac_t FRAC_MAX = frac_t'(16'h7FFF);
    localparam frac_t FRAC_MIN = frac_t'(16'h8000);
    localparam unit_t UNIT_MAX = {UNIT_W{1'b1}};

    // Integer to fixed point (no range check; callers use small constants)
    function automatic frac_t frac_from_int(input int i);
        return frac_t'(i <<< FRAC_FB);
    endfunction

    localparam frac_t FRAC_ONE = frac_from_int(1);

    // Widen a unit fraction into frac_t by aligning binary points
    function automatic frac_t unit_to_frac(input unit_t x);
        return frac_t'({x, {(FRAC_FB - UNIT_W){1'b0}}});
    endfunction

    // Signed fixed-point multiply, truncating toward minus infinity
    function automatic frac_t frac_mul(input frac_t a, input frac_t b);
        logic signed [PROD_W-1:0] p;
        p = PROD_W'(a) * PROD_W'(b);
        return frac_t'(p >>> FRAC_FB);
    endfunction

    // Signed add clamped to the frac_t range, flagging overflow
    function automatic frac_sum_t frac_add_sat(input frac_t a, input frac_t b);
        logic signed [FRAC_W:0] s;
        frac_sum_t              r;
        s     = {a[FRAC_W-1], a} + {b[FRAC_W-1], b};
        r.ovf = s[FRAC_W] ^ s[FRAC_W-1];
        if (r.ovf) begin
            r.sum = s[FRAC_W] ? FRAC_MIN : FRAC_MAX;
        end else begin
            r.sum = s[FRAC_W-1:0];
        end
        return r;
    endfunction

    // Narrow frac_t to unit_t, clamping to [0, UNIT_MAX]
    function automatic unit_t unit_from_frac(input frac_t f);
        if (f[FRAC_W-1]) begin
            return '0;
        end else if (f >= FRAC_ONE) begin
            return UNIT_MAX;
        end else begin
            return f[FRAC_FB-1 -: UNIT_W];
        end
    endfunction

endpackage

// File: rtl/neuron_mac_acc.sv
// Saturating accumulator register with a sticky overflow flag.
module frac_sat_acc
    import neuron_mac_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_load,
    input  frac_t i_load_val,
    input  logic  i_en,
    input  frac_t i_addend,
    output frac_t o_acc,
    output logic  o_sat
);

    frac_t     r_acc;
    logic      r_sat;
    frac_sum_t w_sum;

    assign w_sum = frac_add_sat(r_acc, i_addend);

    // Load wins over accumulate; the sticky flag clears only on load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (i_load) begin
            r_acc <= i_load_val;
            r_sat <= 1'b0;
        end else if (i_en) begin
            r_acc <= w_sum.sum;
            if (w_sum.ovf) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign o_acc = r_acc;
    assign o_sat = r_sat;

endmodule

// File: rtl/neuron_mac.sv
// Sequential single-neuron MAC: bias + sum(x*w), saturating, then activation.
module neuron_mac
    import neuron_mac_pkg::*;
#(
    parameter int unsigned N_INPUTS = 4,
    parameter int unsigned ACT      = 0
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  start,
    input  frac_t bias,
    input  logic  in_valid,
    output logic  in_ready,
    input  unit_t in_x,
    input  frac_t in_w,
    output logic  out_valid,
    input  logic  out_ready,
    output frac_t out_y,
    output unit_t out_u,
    output logic  out_sat,
    output logic  busy
);

    localparam int unsigned       CNT_W   = $clog2(N_INPUTS + 1);
    localparam logic [CNT_W-1:0]  CNT_END = CNT_W'(N_INPUTS);
    localparam act_e              ACT_SEL = act_e'(2'(ACT));

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    frac_t            r_prod;
    logic             r_p_valid;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    frac_t            r_out_y;
    unit_t            r_out_u;

    logic             w_fire;
    logic             w_load;
    logic             w_acc_en;
    logic             w_out_load;
    logic             w_in_ready_nxt;
    logic             w_out_valid_nxt;
    logic             w_busy_nxt;
    frac_t            w_acc;
    logic             w_sat;
    frac_t            w_act;

    assign w_fire = (r_state == ST_ACC) && r_in_ready && in_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, counter and registered-output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_load          = 1'b0;
        w_acc_en        = r_p_valid;
        w_out_load      = 1'b0;
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_ACC;
                end
            end
            ST_ACC: begin
                if (w_fire) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (w_cnt_nxt == CNT_END) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_ACTV;
            end
            ST_ACTV: begin
                w_out_load  = 1'b1;
                w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_in_ready_nxt  = (w_state_nxt == ST_ACC) && (w_cnt_nxt < CNT_END);
        w_out_valid_nxt = (w_state_nxt == ST_OUT);
        w_busy_nxt      = (w_state_nxt != ST_IDLE);
    end

    // Beat counter, product pipeline register and handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_prod      <= '0;
            r_p_valid   <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_p_valid   <= w_fire;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
            if (w_fire) begin
                r_prod <= frac_mul(unit_to_frac(in_x), in_w);
            end
        end
    end

    frac_sat_acc u_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (bias),
        .i_en       (w_acc_en),
        .i_addend   (r_prod),
        .o_acc      (w_acc),
        .o_sat      (w_sat)
    );

    // Activation applied to the final accumulator value
    always_comb begin
        w_act = w_acc;
        case (ACT_SEL)
            ACT_RELU: begin
                if (w_acc[FRAC_W-1]) begin
                    w_act = '0;
                end
            end
            ACT_CLAMP: begin
                if (w_acc[FRAC_W-1]) begin
                    w_act = '0;
                end else if (w_acc > FRAC_ONE) begin
                    w_act = FRAC_ONE;
                end
            end
            default: begin
                w_act = w_acc;
            end
        endcase
    end

    // Result registers, written once per run and held through backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_y <= '0;
            r_out_u <= '0;
        end else if (w_out_load) begin
            r_out_y <= w_act;
            r_out_u <= unit_from_frac(w_act);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;
    assign out_u     = r_out_u;
    assign out_sat   = w_sat;
    assign busy      = r_busy;

endmodule

// File: tb/tb_neuron_mac.sv
// Randomised and directed checks of neuron_mac for all three activations at once.
module tb_neuron_mac;
    import neuron_mac_pkg::*;

    localparam int N   = 4;
    localparam int ONE = 4096;   // 1.0 in Q3.12

    logic  clk       = 1'b0;
    logic  rst_n     = 1'b0;
    logic  start     = 1'b0;
    logic  in_valid  = 1'b0;
    logic  out_ready = 1'b0;
    frac_t bias      = '0;
    unit_t in_x      = '0;
    frac_t in_w      = '0;

    logic  in_ready  [3];
    logic  out_valid [3];
    logic  out_sat   [3];
    logic  busy      [3];
    frac_t out_y     [3];
    unit_t out_u     [3];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Test-plan vectors: x in units of 1/256, w in units of 1/4096
    int bx [N] = '{26, 77, 154, 230};          // 0.1 0.3 0.6 0.9
    int bw [N] = '{4096, 8192, -4096, 2048};   // 1 2 -1 0.5
    int hx [N] = '{128, 128, 128, 128};        // 0.5
    int wn [N] = '{-8192, -8192, -8192, -8192};
    int wp [N] = '{1024, 1024, 1024, 1024};    // 0.25
    int sx [N] = '{230, 230, 230, 230};
    int sw [N] = '{32767, 32767, 32767, 32767};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        neuron_mac #(.N_INPUTS(N), .ACT(g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start),
            .bias      (bias),
            .in_valid  (in_valid),
            .in_ready  (in_ready[g]),
            .in_x      (in_x),
            .in_w      (in_w),
            .out_valid (out_valid[g]),
            .out_ready (out_ready),
            .out_y     (out_y[g]),
            .out_u     (out_u[g]),
            .out_sat   (out_sat[g]),
            .busy      (busy[g])
        );
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Real-valued product x*w rounded down to the 1/4096 grid
    function automatic int q_prod(input int x, input int w);
        int p;
        int q;
        p = x * 16 * w;
        q = p / ONE;
        if (p < 0 && (p % ONE) != 0) q = q - 1;
        return q;
    endfunction

    function automatic int model_acc(input int b, input int xs[N], input int ws[N], output bit sat);
        int a;
        a   = b;
        sat = 1'b0;
        for (int i = 0; i < N; i++) begin
            a = a + q_prod(xs[i], ws[i]);
            if (a > 32767) begin
                a = 32767; sat = 1'b1;
            end else if (a < -32768) begin
                a = -32768; sat = 1'b1;
            end
        end
        return a;
    endfunction

    function automatic int model_act(input int a, input int mode);
        if (mode == 1) return (a < 0) ? 0 : a;
        if (mode == 2) return (a < 0) ? 0 : ((a > ONE) ? ONE : a);
        return a;
    endfunction

    function automatic int model_u(input int y);
        if (y < 0) return 0;
        if (y >= ONE) return 255;
        return y / 16;
    endfunction

    // One full run: start, N beats (optional gaps), result, optional stall
    task automatic run_once(input int b, input int xs[N], input int ws[N],
                            input bit gaps, input int stall, input bit poke, input string tag);
        int    t_last;
        int    e_acc;
        bit    e_sat;
        bit    ok;
        bit    moved;
        frac_t y0 [3];
        unit_t u0 [3];
        logic  s0 [3];
        e_acc = model_acc(b, xs, ws, e_sat);
        t_last = 0;
        @(negedge clk);
        start = 1'b1;
        bias  = frac_t'(b);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, int'(busy[0]), 1);
        check({tag, "_inrdy"}, int'(in_ready[0]), 1);
        for (int i = 0; i < N; i++) begin
            if (gaps && i == 1) begin
                in_valid = 1'b0;
                repeat (2) @(negedge clk);
            end
            if (poke && i == 2) start = 1'b1;
            in_valid = 1'b1;
            in_x     = unit_t'(xs[i]);
            in_w     = frac_t'(ws[i]);
            ok = 1'b0;
            for (int k = 0; k < 20 && !ok; k++) begin
                if (in_ready[0]) ok = 1'b1;
                else @(negedge clk);
            end
            if (!ok) begin
                check({tag, "_inrdy_timeout"}, 0, 1);
                in_valid = 1'b0;
                start    = 1'b0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
            t_last = cyc;
            start  = 1'b0;
        end
        in_valid = 1'b0;
        check({tag, "_inrdy_done"}, int'(in_ready[0]), 0);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            if (out_valid[0]) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            check({tag, "_outvld_timeout"}, 0, 1);
            return;
        end
        check({tag, "_latency"}, cyc - t_last + 1, 3);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("%s_y%0d", tag, g), int'(out_y[g]), model_act(e_acc, g));
            check($sformatf("%s_u%0d", tag, g), int'(out_u[g]), model_u(model_act(e_acc, g)));
            check($sformatf("%s_sat%0d", tag, g), int'(out_sat[g]), int'(e_sat));
            y0[g] = out_y[g];
            u0[g] = out_u[g];
            s0[g] = out_sat[g];
        end
        moved = 1'b0;
        if (poke && stall > 0) start = 1'b1;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            start = 1'b0;
            for (int g = 0; g < 3; g++) begin
                if (out_y[g] !== y0[g] || out_u[g] !== u0[g] || out_sat[g] !== s0[g] || out_valid[g] !== 1'b1)
                    moved = 1'b1;
            end
        end
        check({tag, "_stall_stable"}, int'(moved), 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_outvld_drop"}, int'(out_valid[0]), 0);
        check({tag, "_idle"}, int'(busy[0]), 0);
        if (poke) begin
            @(negedge clk);
            check({tag, "_no_queue"}, int'(busy[0]), 0);
        end
    endtask

    // Abort a run after two beats and confirm every output clears at once
    task automatic reset_mid_run();
        @(negedge clk);
        start = 1'b1;
        bias  = frac_t'(2048);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_x     = unit_t'(bx[i]);
            in_w     = frac_t'(bw[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rst_inrdy%0d", g), int'(in_ready[g]), 0);
            check($sformatf("rst_busy%0d", g), int'(busy[g]), 0);
            check($sformatf("rst_outvld%0d", g), int'(out_valid[g]), 0);
            check($sformatf("rst_sat%0d", g), int'(out_sat[g]), 0);
            check($sformatf("rst_y%0d", g), int'(out_y[g]), 0);
            check($sformatf("rst_u%0d", g), int'(out_u[g]), 0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rxs [N];
        int rws [N];
        int d;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_inrdy", int'(in_ready[0]), 0);
        check("reset_outvld", int'(out_valid[0]), 0);
        check("reset_sat", int'(out_sat[0]), 0);
        check("reset_busy", int'(busy[0]), 0);
        check("reset_y", int'(out_y[0]), 0);
        check("reset_u", int'(out_u[0]), 0);

        run_once(2048, bx, bw, 1'b0, 0, 1'b0, "basic");
        d = int'(out_y[0]) - int'(1.05 * 4096.0);
        if (d < 0) d = -d;
        check("basic_approx", int'(d <= 32), 1);
        check("basic_u_max", int'(out_u[0]), 255);
        check("clamp_one", int'(out_y[2]), ONE);

        run_once(0, hx, wn, 1'b0, 0, 1'b0, "relu_neg");
        check("relu_neg_y", int'(out_y[1]), 0);
        check("relu_neg_u", int'(out_u[1]), 0);
        run_once(0, hx, wp, 1'b0, 0, 1'b0, "relu_pos");
        check("relu_pos_y", int'(out_y[1]), 2048);
        check("relu_pos_u", int'(out_u[1]), 128);

        run_once(32766, sx, sw, 1'b0, 0, 1'b0, "sat");
        check("sat_y_max", int'(out_y[0]), 32767);
        check("sat_flag", int'(out_sat[0]), 1);
        run_once(2048, bx, bw, 1'b0, 0, 1'b0, "benign");
        check("benign_sat_clear", int'(out_sat[0]), 0);

        run_once(2048, bx, bw, 1'b1, 5, 1'b1, "flow");

        reset_mid_run();
        run_once(2048, bx, bw, 1'b0, 0, 1'b0, "after_rst");

        run_once(-3 * ONE, bx, bw, 1'b0, 0, 1'b0, "clamp_neg");
        check("clamp_neg_y", int'(out_y[2]), 0);

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < N; i++) begin
                rxs[i] = int'($urandom_range(255, 0));
                rws[i] = int'($urandom_range(65535, 0)) - 32768;
            end
            run_once(int'($urandom_range(65535, 0)) - 32768, rxs, rws,
                     1'($urandom_range(1, 0)), int'($urandom_range(3, 0)),
                     1'($urandom_range(1, 0)), $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
